// File: rtl/result_fifo.sv
// result_fifo: collects result words from the add/sub, multiply and sin/cos
// units into a small show-ahead FIFO that the CPU pops one entry at a time.
// Up to three results can arrive in the same cycle; they are stored in the
// fixed order add, mul, sine. Results that do not fit are dropped and the
// sticky lost flag records it. out_fifo_hold throttles operation issue
// before the FIFO can overflow.
module result_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              add_result,
  input  logic                     add_done,
  input  logic                     add_overflow,
  input  logic [31:0]              mul_result,
  input  logic                     mul_done,
  input  logic                     mul_overflow,
  input  logic [31:0]              sine_result,
  input  logic                     sine_done,
  input  logic                     rd_en,
  output logic [31:0]              result,
  output logic                     done,
  output logic                     overflow,
  output logic [1:0]               src,
  output logic                     out_fifo_hold,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     lost
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 35;
  localparam int NSRC = 3;

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0] HOLD_LIM_C = CW'(3);

  localparam logic [1:0] SRC_ADD  = 2'b00;
  localparam logic [1:0] SRC_MUL  = 2'b01;
  localparam logic [1:0] SRC_SINE = 2'b10;

  // Build one stored entry: {src, overflow, result}.
  function automatic logic [EW-1:0] pack_entry(input logic [1:0]  src_f,
                                                input logic        ovf_f,
                                                input logic [31:0] data_f);
    pack_entry = {src_f, ovf_f, data_f};
  endfunction

  // Storage and control state
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          lost_q, lost_d;
  logic          hold_q, hold_d;

  // Write-side decode
  logic [NSRC-1:0] src_vld_s;
  logic [EW-1:0]   src_data_s [NSRC];
  logic [NSRC-1:0] we_s;
  logic [AW-1:0]   waddr_s [NSRC];
  logic [1:0]      acc_s;
  logic            drop_s;
  logic [CW-1:0]   free_s;
  logic [CW-1:0]   free_nxt_s;
  logic            rd_acc_s;
  logic [EW-1:0]   head_s;

  // Gather the three result sources in storage order; sine never overflows.
  always_comb begin
    src_vld_s     = {sine_done, mul_done, add_done};
    src_data_s[0] = pack_entry(SRC_ADD,  add_overflow, add_result);
    src_data_s[1] = pack_entry(SRC_MUL,  mul_overflow, mul_result);
    src_data_s[2] = pack_entry(SRC_SINE, 1'b0,         sine_result);
  end

  // Assign consecutive slots to the incoming results until the free space
  // seen before this edge runs out; anything beyond that is dropped.
  // A same-cycle pop deliberately does not make room here.
  always_comb begin
    free_s = DEPTH_C - count_q;
    acc_s  = 2'd0;
    drop_s = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      we_s[k]    = 1'b0;
      waddr_s[k] = wr_ptr_q;
      if (src_vld_s[k]) begin
        if ({{(CW-2){1'b0}}, acc_s} < free_s) begin
          we_s[k]    = 1'b1;
          waddr_s[k] = wr_ptr_q + AW'(acc_s);
          acc_s      = acc_s + 2'd1;
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        we_s[k] = 1'b0;
      end
    end
  end

  // Next-state pointers, occupancy, sticky loss and issue back-pressure.
  always_comb begin
    rd_acc_s   = rd_en && (count_q != '0);
    wr_ptr_d   = wr_ptr_q + AW'(acc_s);
    rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, rd_acc_s};
    count_d    = count_q + {{(CW-2){1'b0}}, acc_s} - {{(CW-1){1'b0}}, rd_acc_s};
    lost_d     = lost_q | drop_s;
    free_nxt_s = DEPTH_C - count_d;
    hold_d     = (free_nxt_s < HOLD_LIM_C);
  end

  // Control registers; reset discards any same-cycle pulses and pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lost_q   <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lost_q   <= lost_d;
      hold_q   <= hold_d;
    end
  end

  // Entry storage; left uncleared because empty-FIFO outputs are forced to 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NSRC; k++) begin
        if (we_s[k]) begin
          mem_q[waddr_s[k]] <= src_data_s[k];
        end
      end
    end
  end

  // Show-ahead head entry straight from storage, zeroed while empty.
  always_comb begin
    if (count_q != '0) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = '0;
    end
    result   = head_s[31:0];
    overflow = head_s[32];
    src      = head_s[34:33];
    done     = (count_q != '0);
  end

  assign out_fifo_hold = hold_q;
  assign count         = count_q;
  assign lost          = lost_q;

endmodule

// File: doc/result_fifo.md
RESULT_FIFO -- requirements
Module: result_fifo

Interface
REQ-001 Parameter DEPTH, default 8, meaning FIFO entries; SHALL be a power of 2, range 4..16.
REQ-002 clk  input  1  rising-edge clock; all state SHALL change only on this edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 add_result  input  32  add/sub unit result word.
REQ-005 add_done  input  1  one-cycle pulse; add_result/add_overflow valid this cycle.
REQ-006 add_overflow  input  1  add/sub overflow flag.
REQ-007 mul_result  input  32  multiply unit result word.
REQ-008 mul_done  input  1  one-cycle pulse; mul_result/mul_overflow valid this cycle.
REQ-009 mul_overflow  input  1  multiply overflow flag.
REQ-010 sine_result  input  32  sin/cos unit result word.
REQ-011 sine_done  input  1  one-cycle pulse; sine_result valid this cycle.
REQ-012 rd_en  input  1  CPU pop request for the head entry.
REQ-013 result  output  32  head entry data.
REQ-014 done  output  1  high when FIFO non-empty; result/overflow/src valid.
REQ-015 overflow  output  1  head entry overflow flag.
REQ-016 src  output  2  head entry source: 00 add, 01 mul, 10 sine; 11 never produced.
REQ-017 out_fifo_hold  output  1  back-pressure to input decode; no new operations issued while high.
REQ-018 count  output  log2(DEPTH)+1  current occupancy.
REQ-019 lost  output  1  sticky flag: at least one result dropped.

Function
REQ-020 Each entry SHALL store 35 bits: {src[1:0], overflow, result[31:0]}.
REQ-021 Sine results SHALL be stored with overflow = 0.
REQ-022 Write count per cycle SHALL equal the number of asserted done inputs (0..3).
REQ-023 Simultaneous writes SHALL occupy consecutive slots in fixed order add, mul, sine; add is nearest the head.
REQ-024 Free space for writes SHALL be DEPTH - count sampled before the edge; a same-cycle read SHALL NOT free space for same-cycle writes.
REQ-025 When writes exceed free space, the first free-space writes in REQ-023 order SHALL be stored, the rest discarded, and lost set to 1.
REQ-026 lost SHALL clear only on rst.
REQ-027 Read: rd_en = 1 with count > 0 SHALL advance the head pointer by one at the edge.
REQ-028 rd_en = 1 with count = 0 SHALL be ignored; no pointer or count change.
REQ-029 Simultaneous read and writes SHALL update count as count + writes_accepted - read_accepted in one edge.
REQ-030 result/overflow/src SHALL show the head entry (show-ahead), driven from storage without extra register delay.
REQ-031 An entry written at edge N SHALL appear at the outputs from edge N onward if the FIFO was empty; latency is 1 cycle done-to-done.
REQ-032 When count = 0, outputs SHALL be result = 0, overflow = 0, src = 00, done = 0.
REQ-033 Read and write pointers SHALL wrap modulo DEPTH with no gap or duplicate.
REQ-034 out_fifo_hold SHALL be registered and equal 1 when the next-state free space is < 3; otherwise 0.
REQ-035 count SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-036 On rst = 1 at an edge, pointers, count, lost and out_fifo_hold SHALL clear to 0; done = 0, result = 0, overflow = 0, src = 00.
REQ-037 rst SHALL take priority over same-cycle done pulses and rd_en; those inputs are discarded.
REQ-038 Storage contents need not be cleared; outputs SHALL still read 0 per REQ-032.

Verification
REQ-039 Single add: add_done = 1, add_result = 0x40400000, add_overflow = 0 -> next cycle done = 1, result = 0x40400000, src = 00, count = 1; rd_en pop -> done = 0, count = 0.
REQ-040 Triple simultaneous: add/mul/sine done together with 0x1, 0x2, 0x3, mul_overflow = 1 -> pops yield (0x1, src 00, ovf 0), (0x2, src 01, ovf 1), (0x3, src 10, ovf 0).
REQ-041 Fill: DEPTH = 8, count = 6, three done pulses -> add and mul stored, sine dropped, count = 8, lost = 1, out_fifo_hold = 1.
REQ-042 Hold threshold: count 5 -> hold = 1 after the write making count 6; pop to 5 -> hold = 0 next cycle.
REQ-043 Wrap: 20 write/read pairs with incrementing data -> read order exact, count stays 0..1, no loss.
REQ-044 Mid-operation reset: count = 4, rst with add_done and rd_en high -> count = 0, done = 0, lost = 0, result = 0 next cycle.
